// File: rtl/time_counter_if.sv
`default_nettype none
// ============================================================================
// Module      : time_counter_if
// Description : Control inputs and time/status outputs of the time counter.
// Revision    : 1.0 - initial release
// ============================================================================
interface time_counter_if;
    logic       run_en;
    logic       key_mode;
    logic       key_inc;
    logic [5:0] hour;
    logic [5:0] minute;
    logic [5:0] second;
    logic [1:0] mode;
    logic       sec_pulse;
    logic       day_pulse;

    modport master (
        output run_en, key_mode, key_inc,
        input  hour, minute, second, mode, sec_pulse, day_pulse
    );

    modport slave (
        input  run_en, key_mode, key_inc,
        output hour, minute, second, mode, sec_pulse, day_pulse
    );
endinterface
`default_nettype wire

// File: rtl/time_counter.sv
`default_nettype none
// ============================================================================
// Module      : time_counter
// Description : 1 Hz prescaler with hh:mm:ss counters and a key-driven set mode.
// Revision    : 1.0 - initial release
// ============================================================================
module time_counter #(
    parameter int CLK_HZ = 50000000
) (
    input  wire logic    clk,
    input  wire logic    reset,
    time_counter_if.slave bus
);
    localparam int                CNT_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [CNT_W-1:0]  C_TC  = CNT_W'(CLK_HZ - 1);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_SET_HOUR = 2'd1,
        ST_SET_MIN  = 2'd2,
        ST_SET_SEC  = 2'd3
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_count, w_count_nxt;
    logic [5:0]       r_hour, w_hour_nxt;
    logic [5:0]       r_minute, w_minute_nxt;
    logic [5:0]       r_second, w_second_nxt;
    logic             r_sec_pulse, w_sec_pulse_nxt;
    logic             r_day_pulse, w_day_pulse_nxt;
    logic             r_key_mode_q, r_key_inc_q;
    logic             w_mode_edge, w_inc_edge;

    assign w_mode_edge = bus.key_mode & ~r_key_mode_q;
    assign w_inc_edge  = bus.key_inc  & ~r_key_inc_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_RUN;
            r_count      <= '0;
            r_hour       <= 6'd0;
            r_minute     <= 6'd0;
            r_second     <= 6'd0;
            r_sec_pulse  <= 1'b0;
            r_day_pulse  <= 1'b0;
            // A key held through reset must not register as a fresh press.
            r_key_mode_q <= 1'b1;
            r_key_inc_q  <= 1'b1;
        end else begin
            r_state      <= w_state_nxt;
            r_count      <= w_count_nxt;
            r_hour       <= w_hour_nxt;
            r_minute     <= w_minute_nxt;
            r_second     <= w_second_nxt;
            r_sec_pulse  <= w_sec_pulse_nxt;
            r_day_pulse  <= w_day_pulse_nxt;
            r_key_mode_q <= bus.key_mode;
            r_key_inc_q  <= bus.key_inc;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_count_nxt     = '0;
        w_hour_nxt      = r_hour;
        w_minute_nxt    = r_minute;
        w_second_nxt    = r_second;
        w_sec_pulse_nxt = 1'b0;
        w_day_pulse_nxt = 1'b0;

        case (r_state)
            ST_RUN: begin
                // A mode step wins over a coincident terminal count.
                if (w_mode_edge) begin
                    w_state_nxt = ST_SET_HOUR;
                end else if (!bus.run_en) begin
                    w_count_nxt = r_count;
                end else if (r_count != C_TC) begin
                    w_count_nxt = r_count + CNT_W'(1);
                end else begin
                    w_sec_pulse_nxt = 1'b1;
                    w_second_nxt    = (r_second == 6'd59) ? 6'd0 : r_second + 6'd1;
                    if (r_second == 6'd59) begin
                        w_minute_nxt = (r_minute == 6'd59) ? 6'd0 : r_minute + 6'd1;
                        if (r_minute == 6'd59) begin
                            w_hour_nxt      = (r_hour == 6'd23) ? 6'd0 : r_hour + 6'd1;
                            w_day_pulse_nxt = (r_hour == 6'd23);
                        end
                    end
                end
            end
            ST_SET_HOUR: begin
                if (w_mode_edge)
                    w_state_nxt = ST_SET_MIN;
                else if (w_inc_edge)
                    w_hour_nxt = (r_hour == 6'd23) ? 6'd0 : r_hour + 6'd1;
            end
            ST_SET_MIN: begin
                if (w_mode_edge)
                    w_state_nxt = ST_SET_SEC;
                else if (w_inc_edge)
                    w_minute_nxt = (r_minute == 6'd59) ? 6'd0 : r_minute + 6'd1;
            end
            ST_SET_SEC: begin
                if (w_mode_edge)
                    w_state_nxt = ST_RUN;
                else if (w_inc_edge)
                    w_second_nxt = (r_second == 6'd59) ? 6'd0 : r_second + 6'd1;
            end
            default: w_state_nxt = ST_RUN;
        endcase
    end

    assign bus.hour      = r_hour;
    assign bus.minute    = r_minute;
    assign bus.second    = r_second;
    assign bus.mode      = r_state;
    assign bus.sec_pulse = r_sec_pulse;
    assign bus.day_pulse = r_day_pulse;
endmodule
`default_nettype wire

// File: tb/tb_time_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_time_counter
// Description : Directed stimulus with an output-change scoreboard for time_counter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_time_counter;
    localparam int CLK_HZ = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    time_counter_if bus ();

    time_counter #(.CLK_HZ(CLK_HZ)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct {
        int h; int m; int s; int md; int sp; int dp; int cyc;
    } snap_t;

    snap_t      exp_q[$];
    snap_t      e;
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    bit         mon_en = 1'b0;
    logic [21:0] cur_vec, prev_vec;

    int e_h = 0, e_m = 0, e_s = 0, e_mode = 0, e_sp = 0, e_dp = 0;
    int last_evt = 0;
    int c0, r, k;

    always @(posedge clk) cyc <= cyc + 1;

    // Every change of the output vector must match the next queued snapshot.
    always @(negedge clk) begin
        cur_vec = {bus.hour, bus.minute, bus.second, bus.mode, bus.sec_pulse, bus.day_pulse};
        if (mon_en) begin
            checks++;
            if (bus.hour > 6'd23 || bus.minute > 6'd59 || bus.second > 6'd59) begin
                errors++;
                $display("FAIL range cyc=%0d got %0d:%0d:%0d required h<=23 m<=59 s<=59",
                         cyc, bus.hour, bus.minute, bus.second);
            end
            if (cur_vec != prev_vec) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event cyc=%0d got %0d:%0d:%0d mode=%0d sp=%0d dp=%0d required no change",
                             cyc, bus.hour, bus.minute, bus.second, bus.mode, bus.sec_pulse, bus.day_pulse);
                end else begin
                    e = exp_q.pop_front();
                    if (int'(bus.hour) != e.h || int'(bus.minute) != e.m || int'(bus.second) != e.s ||
                        int'(bus.mode) != e.md || int'(bus.sec_pulse) != e.sp ||
                        int'(bus.day_pulse) != e.dp || cyc != e.cyc) begin
                        errors++;
                        $display("FAIL event got cyc=%0d %0d:%0d:%0d mode=%0d sp=%0d dp=%0d required cyc=%0d %0d:%0d:%0d mode=%0d sp=%0d dp=%0d",
                                 cyc, bus.hour, bus.minute, bus.second, bus.mode, bus.sec_pulse, bus.day_pulse,
                                 e.cyc, e.h, e.m, e.s, e.md, e.sp, e.dp);
                    end
                end
            end
        end
        prev_vec = cur_vec;
    end

    task automatic chk(input string nm, input int got, input int expv);
        checks++;
        if (got != expv) begin
            errors++;
            $display("FAIL %s got %0d required %0d", nm, got, expv);
        end
    endtask

    task automatic push(input int at_cyc);
        snap_t s;
        s.h = e_h; s.m = e_m; s.s = e_s; s.md = e_mode; s.sp = e_sp; s.dp = e_dp; s.cyc = at_cyc;
        exp_q.push_back(s);
    endtask

    // Called on a falling edge; returns two falling edges later.
    task automatic press_mode();
        bus.key_mode = 1'b1;
        e_mode = (e_mode + 1) % 4;
        last_evt = cyc + 1;
        push(last_evt);
        @(negedge clk);
        bus.key_mode = 1'b0;
        @(negedge clk);
    endtask

    task automatic press_inc();
        bus.key_inc = 1'b1;
        if (e_mode != 0) begin
            case (e_mode)
                1:       e_h = (e_h + 1) % 24;
                2:       e_m = (e_m + 1) % 60;
                default: e_s = (e_s + 1) % 60;
            endcase
            push(cyc + 1);
        end
        @(negedge clk);
        bus.key_inc = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        bus.run_en   = 1'b0;
        bus.key_mode = 1'b0;
        bus.key_inc  = 1'b0;
        reset        = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_hour",   int'(bus.hour), 0);
        chk("rst_minute", int'(bus.minute), 0);
        chk("rst_second", int'(bus.second), 0);
        chk("rst_mode",   int'(bus.mode), 0);
        chk("rst_sp",     int'(bus.sec_pulse), 0);
        chk("rst_dp",     int'(bus.day_pulse), 0);

        // Free run for one minute: a tick every 4 cycles, first on cycle 4.
        reset = 1'b0;
        bus.run_en = 1'b1;
        mon_en = 1'b1;
        c0 = cyc;
        for (int i = 1; i <= 60; i++) begin
            e_s = i % 60; e_m = i / 60; e_sp = 1;
            push(c0 + 4 * i);
            e_sp = 0;
            push(c0 + 4 * i + 1);
        end
        repeat (240) @(negedge clk);
        chk("run_hour",   int'(bus.hour), 0);
        chk("run_minute", int'(bus.minute), 1);
        chk("run_second", int'(bus.second), 0);
        chk("run_sp",     int'(bus.sec_pulse), 1);
        @(negedge clk);

        // Set 23:59:59 starting from 00:01:00.
        press_mode();
        repeat (23) press_inc();
        press_mode();
        repeat (58) press_inc();
        press_mode();
        repeat (59) press_inc();
        press_mode();
        r = last_evt;
        chk("set_hour",   int'(bus.hour), 23);
        chk("set_minute", int'(bus.minute), 59);
        chk("set_second", int'(bus.second), 59);

        // Day wrap four cycles after returning to RUN.
        e_h = 0; e_m = 0; e_s = 0; e_sp = 1; e_dp = 1;
        push(r + 4);
        e_sp = 0; e_dp = 0;
        push(r + 5);
        repeat (3) @(negedge clk);
        chk("wrap_dp",   int'(bus.day_pulse), 1);
        chk("wrap_sp",   int'(bus.sec_pulse), 1);
        chk("wrap_hour", int'(bus.hour), 0);
        @(negedge clk);
        chk("wrap_dp_one_cycle", int'(bus.day_pulse), 0);

        // Mode edge lands on the terminal count: tick suppressed.
        repeat (2) @(negedge clk);
        press_mode();
        repeat (23) press_inc();
        chk("hour_23", int'(bus.hour), 23);
        press_inc();
        chk("hour_wrap",     int'(bus.hour), 0);
        chk("hour_wrap_min", int'(bus.minute), 0);
        chk("hour_wrap_sec", int'(bus.second), 0);
        bus.key_inc = 1'b1;
        e_h = 1;
        push(cyc + 1);
        repeat (20) @(negedge clk);
        bus.key_inc = 1'b0;
        @(negedge clk);
        chk("held_inc_once", int'(bus.hour), 1);
        press_mode();
        press_mode();
        press_mode();
        r = last_evt;

        // Pause at prescaler count 2 for ten cycles.
        @(negedge clk);
        bus.run_en = 1'b0;
        repeat (10) @(negedge clk);
        chk("pause_second", int'(bus.second), 0);
        bus.run_en = 1'b1;
        e_s = 1; e_sp = 1;
        push(r + 14);
        e_sp = 0;
        push(r + 15);
        repeat (3) @(negedge clk);
        chk("resume_second", int'(bus.second), 1);

        // Simultaneous mode and inc edges: mode wins, increment dropped.
        bus.key_mode = 1'b1; bus.key_inc = 1'b1;
        e_mode = 1;
        push(cyc + 1);
        @(negedge clk);
        bus.key_mode = 1'b0; bus.key_inc = 1'b0;
        @(negedge clk);
        chk("both_run_mode", int'(bus.mode), 1);
        chk("both_run_hour", int'(bus.hour), 1);
        bus.key_mode = 1'b1; bus.key_inc = 1'b1;
        e_mode = 2;
        push(cyc + 1);
        @(negedge clk);
        bus.key_mode = 1'b0; bus.key_inc = 1'b0;
        @(negedge clk);
        chk("both_set_mode", int'(bus.mode), 2);
        chk("both_set_hour", int'(bus.hour), 1);

        // Reach 12:34:56 in SET_MIN.
        repeat (34) press_inc();
        press_mode();
        repeat (55) press_inc();
        press_mode();
        press_mode();
        repeat (11) press_inc();
        press_mode();
        chk("pre_rst_hour",   int'(bus.hour), 12);
        chk("pre_rst_minute", int'(bus.minute), 34);
        chk("pre_rst_second", int'(bus.second), 56);
        chk("pre_rst_mode",   int'(bus.mode), 2);

        // Reset with key_mode held through it.
        reset = 1'b1;
        bus.key_mode = 1'b1;
        k = cyc;
        e_h = 0; e_m = 0; e_s = 0; e_mode = 0;
        push(k + 1);
        @(negedge clk);
        reset = 1'b0;
        e_s = 1; e_sp = 1;
        push(k + 5);
        e_sp = 0;
        push(k + 6);
        repeat (3) @(negedge clk);
        chk("held_mode_after_rst", int'(bus.mode), 0);
        bus.key_mode = 1'b0;
        repeat (2) @(negedge clk);
        bus.run_en = 1'b0;
        repeat (4) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
